// File: rtl/cache_pkg.sv
// Shared types and address helpers for the instruction cache slice.
package cache_pkg;

  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned LINE_BITS   = LINE_BYTES * 8;
  localparam int unsigned OFFSET_BITS = 4;

  typedef enum logic {
    IDLE,
    MISS
  } icache_state_t;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

  function automatic logic [1:0] word_sel(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  // Little-endian: word w occupies line[w*32 +: 32].
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [1:0]           w);
    return line[{w, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Data/tag/valid arrays: one write port, one combinational read port, bulk valid clear.
module icache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IB        = $clog2(NUM_LINES),
  parameter int unsigned TAG_BITS  = 32 - OFFSET_BITS - IB
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_valid,
  input  logic                 wr_en,
  input  logic [IB-1:0]        wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic [IB-1:0]        rd_index,
  output logic                 rd_valid,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_data
);

  logic [NUM_LINES-1:0] valid;
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];

  // Clear takes priority so an invalidate can veto a coincident install.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (clear_valid) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_line_fetcher.sv
// Direct-mapped read-only instruction cache; fetches 128-bit lines on a miss.
module icache_line_fetcher
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_fetch_valid,
  input  logic [31:0]               in_fetch_addr,
  input  logic                      in_invalidate,
  output logic [31:0]               out_fetch_data,
  output logic                      out_fetch_ready,
  output logic                      out_stall,
  output logic                      out_mem_read_en,
  output logic                      out_mem_write_en,
  output logic [31:0]               out_mem_addr,
  output logic [127:0]              out_mem_write_data,
  input  logic [LINE_BYTES*8-1:0]   in_mem_read_data,
  input  logic                      in_mem_ready
);

  localparam int unsigned IB       = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = 32 - OFFSET_BITS - IB;

  icache_state_t state, state_next;

  logic [31:0]          mem_addr_q;
  logic                 miss_capture;
  logic                 fill;
  logic                 hit;
  logic                 rd_valid;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic [IB-1:0]        fetch_index;
  logic [TAG_BITS-1:0]  fetch_tag;
  logic                 unused_addr_bits;

  assign fetch_index      = in_fetch_addr[OFFSET_BITS +: IB];
  assign fetch_tag        = in_fetch_addr[31 -: TAG_BITS];
  assign unused_addr_bits = ^in_fetch_addr[1:0];
  assign hit              = in_fetch_valid & rd_valid & (rd_tag == fetch_tag);

  // Fill index/tag come from the held miss address, so a fill completes even if fetch drops valid.
  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IB        (IB),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .clear_valid (in_invalidate),
    .wr_en       (fill),
    .wr_index    (mem_addr_q[OFFSET_BITS +: IB]),
    .wr_tag      (mem_addr_q[31 -: TAG_BITS]),
    .wr_data     (in_mem_read_data),
    .rd_index    (fetch_index),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr_q <= '0;
    end else begin
      state <= state_next;
      if (miss_capture) begin
        mem_addr_q <= line_addr(in_fetch_addr);
      end
    end
  end

  always_comb begin
    state_next      = state;
    out_fetch_ready = 1'b0;
    out_fetch_data  = '0;
    out_stall       = 1'b0;
    out_mem_read_en = 1'b0;
    miss_capture    = 1'b0;
    fill            = 1'b0;
    case (state)
      IDLE: begin
        if (in_fetch_valid) begin
          if (hit) begin
            out_fetch_ready = 1'b1;
            out_fetch_data  = line_word(rd_data, word_sel(in_fetch_addr));
          end else begin
            out_stall    = 1'b1;
            miss_capture = 1'b1;
            state_next   = MISS;
          end
        end
      end
      MISS: begin
        out_stall       = 1'b1;
        out_mem_read_en = ~in_mem_ready;
        if (in_mem_ready) begin
          fill       = ~in_invalidate;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_mem_addr       = mem_addr_q;
  assign out_mem_write_en   = 1'b0;
  assign out_mem_write_data = '0;

endmodule
